// File: rtl/neuron.sv
// Single-synapse spiking neuron: saturating 5-bit membrane potential that fires
// a one-cycle positive or negative output spike when it reaches +/-threshold.
module neuron (
    input  logic       clk,
    input  logic       rst,
    input  logic       weight,
    input  logic [3:0] threshold,
    input  logic       pos_in,
    input  logic       neg_in,
    output logic       pos_out,
    output logic       neg_out
);

    localparam int unsigned POT_W = 5;
    localparam int unsigned EXT_W = POT_W + 1;
    localparam logic signed [EXT_W-1:0] POT_MAX = 6'sd15;
    localparam logic signed [EXT_W-1:0] POT_MIN = -6'sd15;

    logic signed [POT_W-1:0] pot;
    logic signed [EXT_W-1:0] delta_c;
    logic signed [EXT_W-1:0] sum_c;
    logic signed [EXT_W-1:0] nxt_c;
    logic signed [EXT_W-1:0] thr_c;
    logic signed [EXT_W-1:0] neg_thr_c;
    logic                    fire_pos_c;
    logic                    fire_neg_c;

    // Signed step from the input spikes; weight=0 inverts the synapse polarity.
    always_comb begin
        delta_c = 6'sd0;
        if (pos_in && !neg_in) begin
            delta_c = weight ? 6'sd1 : -6'sd1;
        end else if (neg_in && !pos_in) begin
            delta_c = weight ? -6'sd1 : 6'sd1;
        end
    end

    // One extra bit of headroom so +/-16 is representable before clamping.
    always_comb begin
        sum_c = $signed({pot[POT_W-1], pot}) + delta_c;
        nxt_c = sum_c;
        if (sum_c > POT_MAX) begin
            nxt_c = POT_MAX;
        end else if (sum_c < POT_MIN) begin
            nxt_c = POT_MIN;
        end
    end

    always_comb begin
        thr_c      = $signed({2'b00, threshold});
        neg_thr_c  = -thr_c;
        fire_pos_c = (threshold != 4'd0) && (nxt_c >= thr_c);
        fire_neg_c = (threshold != 4'd0) && (nxt_c <= neg_thr_c);
    end

    // A fire consumes the potential; the two fire conditions are exclusive
    // because a nonzero threshold cannot be met from both sides at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pot     <= '0;
            pos_out <= 1'b0;
            neg_out <= 1'b0;
        end else begin
            pos_out <= fire_pos_c;
            neg_out <= fire_neg_c;
            if (fire_pos_c || fire_neg_c) begin
                pot <= '0;
            end else begin
                pot <= nxt_c[POT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_neuron.sv
// Bench for neuron: directed scenarios plus randomized traffic, all checked
// against an integer-arithmetic model of the potential and output spikes.
module tb_neuron;

    logic       clk = 1'b0;
    logic       rst;
    logic       weight;
    logic [3:0] threshold;
    logic       pos_in;
    logic       neg_in;
    logic       pos_out;
    logic       neg_out;

    int n_checks = 0;
    int n_fail   = 0;
    int m_pot    = 0;
    int m_pos    = 0;
    int m_neg    = 0;
    int cnt_pos  = 0;
    int cnt_neg  = 0;

    neuron dut (
        .clk       (clk),
        .rst       (rst),
        .weight    (weight),
        .threshold (threshold),
        .pos_in    (pos_in),
        .neg_in    (neg_in),
        .pos_out   (pos_out),
        .neg_out   (neg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one rising edge, from the integrate-and-fire rules.
    task automatic model_edge();
        int d;
        int nxt;
        int thr;
        if (rst) begin
            m_pot = 0;
            m_pos = 0;
            m_neg = 0;
            return;
        end
        d = int'(pos_in) - int'(neg_in);
        if (!weight) d = -d;
        nxt = m_pot + d;
        if (nxt > 15)  nxt = 15;
        if (nxt < -15) nxt = -15;
        thr   = int'(threshold);
        m_pos = 0;
        m_neg = 0;
        if (thr != 0 && nxt >= thr) begin
            m_pos = 1;
            m_pot = 0;
        end else if (thr != 0 && nxt <= -thr) begin
            m_neg = 1;
            m_pot = 0;
        end else begin
            m_pot = nxt;
        end
    endtask

    task automatic step(input logic p, input logic n);
        int got_pot;
        pos_in = p;
        neg_in = n;
        @(posedge clk);
        model_edge();
        #1;
        got_pot = $signed(dut.pot);
        check("pos_out", int'(pos_out), m_pos);
        check("neg_out", int'(neg_out), m_neg);
        check("pot", got_pot, m_pot);
        check("exclusive", int'(pos_out && neg_out), 0);
        cnt_pos += int'(pos_out);
        cnt_neg += int'(neg_out);
    endtask

    task automatic clear_counts();
        cnt_pos = 0;
        cnt_neg = 0;
    endtask

    initial begin
        int got;
        rst       = 1'b1;
        weight    = 1'b1;
        threshold = 4'd0;
        pos_in    = 1'b0;
        neg_in    = 1'b0;
        #12;
        got = $signed(dut.pot);
        check("rst_pot", got, 0);
        check("rst_pos_out", int'(pos_out), 0);
        check("rst_neg_out", int'(neg_out), 0);
        // An edge sampled under reset must discard the spike.
        step(1'b1, 1'b0);
        rst = 1'b0;

        // Excitatory sequence +,-,+,+,-,+,+ with threshold 2.
        weight = 1'b1; threshold = 4'd2; clear_counts();
        step(1,0); step(0,1); step(1,0); step(1,0);
        check("s28_fire", int'(pos_out), 1);
        step(0,1); step(1,0); step(1,0);
        got = $signed(dut.pot);
        check("s28_pot", got, 1);
        check("s28_npos", cnt_pos, 1);
        check("s28_nneg", cnt_neg, 0);

        // Inhibitory synapse turns positive spikes into a negative fire.
        step(0,1);
        weight = 1'b0; clear_counts();
        step(1,0); step(1,0);
        check("s29_npos", cnt_pos, 0);
        check("s29_nneg", cnt_neg, 1);

        // Threshold 1 with a held input fires on every edge.
        weight = 1'b1; threshold = 4'd1; clear_counts();
        repeat (4) step(1,0);
        check("s30_npos", cnt_pos, 4);

        // Simultaneous spikes cancel.
        clear_counts();
        repeat (5) step(1,1);
        check("s32_nout", cnt_pos + cnt_neg, 0);

        // Threshold 0 saturates, then a raised threshold fires on an idle edge.
        threshold = 4'd0; clear_counts();
        repeat (20) step(1,0);
        got = $signed(dut.pot);
        check("s31_sat", got, 15);
        check("s31_nout", cnt_pos + cnt_neg, 0);
        threshold = 4'd15;
        step(0,0);
        check("s31_fire", int'(pos_out), 1);
        got = $signed(dut.pot);
        check("s31_pot0", got, 0);
        repeat (20) step(0,1);
        got = $signed(dut.pot);
        check("s31_negfire", cnt_neg, 1);

        // Asynchronous reset mid-accumulation.
        step(0,0);
        threshold = 4'd3;
        step(1,0); step(1,0);
        #2 rst = 1'b1;
        #1;
        got = $signed(dut.pot);
        check("s33_async_pot", got, 0);
        check("s33_async_out", int'(pos_out | neg_out), 0);
        m_pot = 0; m_pos = 0; m_neg = 0;
        step(1,0);
        rst = 1'b0;
        clear_counts();
        step(1,0); step(1,0);
        check("s33_nofire", cnt_pos, 0);
        step(1,0);
        check("s33_fire", int'(pos_out), 1);

        // Randomized traffic with occasional resets and parameter changes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) weight = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 3) == 0) threshold = 4'($urandom_range(0, 15));
                else threshold = 4'($urandom_range(0, 5));
            end
            rst = ($urandom_range(0, 59) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rst = 1'b0;
        step(0,0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron.md
NEURON -- requirements
Module: neuron

Interface
REQ-001 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 Port weight, input, 1 bit: synapse polarity; 1 = excitatory, 0 = inhibitory (inverted).
REQ-004 Port threshold, input, 4 bits: unsigned firing magnitude; 0 disables firing.
REQ-005 Port pos_in, input, 1 bit: positive input spike.
REQ-006 Port neg_in, input, 1 bit: negative input spike.
REQ-007 Port pos_out, output, 1 bit: positive output spike; registered; one-cycle pulse.
REQ-008 Port neg_out, output, 1 bit: negative output spike; registered; one-cycle pulse.
REQ-009 No parameters; all widths fixed as listed.

Function
REQ-010 Inputs SHALL be synchronous to clk, sampled on each rising edge; a spike is one sampled-high cycle, and a level held N cycles counts as N spikes.
REQ-011 Internal membrane potential SHALL be a 5-bit two's-complement register, pot, with range -15..+15.
REQ-012 Per-edge delta SHALL be (pos_in - neg_in) when weight=1, and (neg_in - pos_in) when weight=0.
REQ-013 pos_in and neg_in high on the same edge SHALL produce delta 0.
REQ-014 Candidate value SHALL be nxt = pot + delta, saturated to -15..+15; pot SHALL never wrap.
REQ-015 When threshold != 0 and nxt >= +threshold, the neuron SHALL set pos_out=1 for exactly the following cycle and load pot with 0.
REQ-016 When threshold != 0 and nxt <= -threshold, the neuron SHALL set neg_out=1 for exactly the following cycle and load pot with 0.
REQ-017 Otherwise the neuron SHALL load pot with nxt, and pos_out and neg_out SHALL be 0.
REQ-018 When threshold == 0, pos_out and neg_out SHALL stay 0, and pot SHALL integrate with saturation per REQ-014.
REQ-019 pos_out and neg_out SHALL never be high in the same cycle.
REQ-020 Latency: the output pulse SHALL be visible after the same rising edge that samples the crossing input, i.e. 1 cycle from input to output.
REQ-021 threshold and weight SHALL be sampled on every edge; a change takes effect on the next edge with no reset of pot.
REQ-022 Firing SHALL also occur on a zero-delta edge if pot already meets a newly lowered threshold.
REQ-023 Back-to-back fires SHALL be possible on consecutive edges, e.g. threshold=1 with pos_in held high.

Reset
REQ-024 While rst=1, pot, pos_out and neg_out SHALL be 0 immediately, independent of clk.
REQ-025 Deassertion of rst SHALL take effect at the next rising edge.
REQ-026 Inputs sampled while rst=1 SHALL be discarded.
REQ-027 Reset mid-accumulation SHALL lose the partial potential.

Verification
REQ-028 Scenario: weight=1, threshold=2; single-cycle spikes +,-,+,+,-,+,+ on separate edges -> pot 1,0,1,fire(0),-1,0,1; exactly one pos_out pulse, on the 4th spike; neg_out never high.
REQ-029 Scenario: weight=0, threshold=2; two pos_in spikes -> one neg_out pulse after the 2nd; pos_out stays 0.
REQ-030 Scenario: threshold=1, weight=1; pos_in held 4 cycles -> pos_out high 4 consecutive cycles.
REQ-031 Scenario: threshold=0; pos_in held 20 cycles -> no outputs, pot saturates at +15; then set threshold=15 with inputs idle -> pos_out pulses once, and pot becomes 0.
REQ-032 Scenario: pos_in=neg_in=1 for 5 cycles at threshold=1 -> no outputs, pot unchanged.
REQ-033 Scenario: threshold=3; 2 pos spikes, assert rst asynchronously mid-cycle -> pot and outputs 0 at once; after release, 2 more pos spikes -> no fire; a 3rd pos spike -> pos_out pulse.
